seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit 7-segment driver.
- Samples the strobed anode/segment/decimal-point lines and filters out scan transitions.
- Decodes each segment pattern back to a hex nibble and presents all four digits as a parallel word with valid flags and a frame strobe.
- Used for on-board loopback self-test of the display path and as a bench monitor.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronized samples required before a sample is committed (legal range 1..65535)
TIMEOUT_CYCLES, 4194304, clocks without any commit before all captured state is discarded
TO_W, 23, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous, active-low reset
AnIn  input  4  anode lines, active low, bit0 = digit 0
SegIn  input  7  segment lines, active low, bit0 = a … bit6 = g
DpIn  input  1  decimal point line, active low
Digits  output  16  decoded nibbles, [3:0] = digit 0 … [15:12] = digit 3
DigValid  output  4  per-digit flag: last commit was a recognised hex glyph
DpCapt  output  4  per-digit captured decimal point, 1 = lit
FrameStb  output  1  one-cycle pulse when all four digits have been committed since the last frame
BadPat  output  1  one-cycle pulse: a committed glyph was unrecognised
BadAn  output  1  one-cycle pulse: a stable sample had more than one anode low

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; synchronizers, held sample, counters and the seen mask cleared. Held sample resets to all-high (blank).
- Input capture: AnIn, SegIn and DpIn (12 bits) pass through a 2-flop synchronizer. The second stage is compared every clock with the held sample.
  - Sample differs: load the held sample, stab_cnt <= 0, committed <= 0.
  - Sample equal and stab_cnt < STABLE_CYCLES-1: increment stab_cnt.
  - stab_cnt == STABLE_CYCLES-1 and committed == 0: evaluate the held sample once, then committed <= 1. A single stable episode never evaluates twice.
- Latency: an input change settled before edge k produces updated outputs or pulses on edge k+STABLE_CYCLES+2.
- Evaluation of the held sample:
  - Anode all high: blanking interval; ignored, no pulse.
  - More than one anode low: BadAn pulse; no digit update.
  - Exactly one anode low (digit i): commit digit i. DpCapt[i] <= ~Dp, and seen[i] <= 1.
- Glyph decode (active-low pattern g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Match: Digits nibble i <= code, DigValid[i] <= 1.
  - 1111111 (blank): nibble <= 0, DigValid[i] <= 0, no error.
  - Any other pattern: nibble <= 0, DigValid[i] <= 0, BadPat pulse.
- Frame:
  - If seen becomes 1111 on a commit (including that commit), FrameStb pulses for one cycle and seen is cleared in the same cycle.
  - Re-commit of an already-seen digit before frame completion overwrites its nibble and DP; seen is unchanged.
- Timeout:
  - Counter cleared on every commit, incremented otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: DigValid <= 0, seen <= 0. Digits and DpCapt keep their values. Repeats only after a further commit plus a full timeout.
- Simultaneous events: a commit in the same cycle the timeout would fire takes priority; the counter is cleared and nothing is discarded.
- Reset mid-operation: asynchronous return to reset state; no pulse is emitted on reset release.

Test Plan:
- Reset: hold RST_N=0 with arbitrary inputs → all outputs 0; after release with inputs static-blank, no pulses for 100 clocks.
- Nominal scan, STABLE_CYCLES=4: present AnIn 1110/1101/1011/0111 with glyphs F,b,C,d, each held 10 clocks → Digits=16'hDCBF, DigValid=1111, one FrameStb on the 4th commit exactly 6 edges after the 4th change.
- Glitch rejection: insert a 3-clock 1011/0000000 between digits (STABLE_CYCLES=4) → no commit, Digits unchanged, no pulses.
- Errors: stable AnIn=1100 → BadAn pulse, no update. Stable AnIn=1110 with Seg=1010101 → BadPat pulse, DigValid[0]=0, Digits[3:0]=0. DP low on digit 2 → DpCapt[2]=1.
- Frame/overwrite: commit digits 0,1,0,2,3 → single FrameStb on the digit-3 commit; Digits[3:0] holds the second value.
- Timeout (TIMEOUT_CYCLES=50): after a full frame, hold AnIn=1111 → DigValid=0000 on the 50th clock after the last commit, Digits retained. Repeat with a commit landing on that exact cycle → DigValid not cleared.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive-side counterpart of a multiplexed 4-digit 7-segment driver. The
// strobed anode / segment / decimal-point lines are synchronised, filtered
// until they have been stable for STABLE_CYCLES samples, and each stable
// sample is evaluated once. Recognised glyphs are decoded back to hex
// nibbles and presented as a parallel 16-bit word with per-digit valid and
// decimal-point flags. A frame strobe marks the point where every digit has
// been committed since the previous frame. If no digit is committed for
// TIMEOUT_CYCLES clocks the valid flags and the frame progress are dropped.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed before a commit (1..65535)
//   TIMEOUT_CYCLES clocks without a digit commit before valid state is discarded
//   TO_W           width of the timeout counter, 2**TO_W > TIMEOUT_CYCLES
//
// Ports:
//   CLK       system clock
//   RST_N     asynchronous active-low reset
//   AnIn      anode lines, active low, bit0 = digit 0
//   SegIn     segment lines, active low, bit0 = a ... bit6 = g
//   DpIn      decimal point line, active low
//   Digits    decoded nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   DigValid  per digit: last commit was a recognised hex glyph
//   DpCapt    per digit: captured decimal point, 1 = lit
//   FrameStb  one-cycle pulse when all four digits have been committed
//   BadPat    one-cycle pulse when a committed glyph was not recognised
//   BadAn     one-cycle pulse when a stable sample had several anodes low
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4194304,
  parameter int unsigned TO_W           = 23
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  AnIn,
  input  logic [6:0]  SegIn,
  input  logic        DpIn,
  output logic [15:0] Digits,
  output logic [3:0]  DigValid,
  output logic [3:0]  DpCapt,
  output logic        FrameStb,
  output logic        BadPat,
  output logic        BadAn
);

  // All display lines are active low, so "everything high" is the idle,
  // blanked state. Synchronisers and the held sample start there so that
  // leaving reset with a dark display never looks like a change.
  localparam logic [11:0] SAMPLE_IDLE = 12'hFFF;

  localparam logic [15:0]     STAB_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  // Sample layout: {anodes[3:0], dp, segments g..a}
  logic [11:0] sample_in;
  logic [11:0] sync1;
  logic [11:0] sync2;
  logic [11:0] held;
  logic [15:0] stab_cnt;
  logic        committed;

  logic [TO_W-1:0] to_cnt;
  logic [3:0]      seen;

  logic [3:0] held_an;
  logic       held_dp;
  logic [6:0] held_seg;
  logic [3:0] an_act;
  logic       an_blank;
  logic       an_multi;
  logic [1:0] dig_idx;
  logic       eval_now;
  logic       commit;
  logic [4:0] glyph;
  logic       glyph_hit;
  logic [3:0] glyph_code;
  logic [3:0] seen_next;

  assign sample_in = {AnIn, DpIn, SegIn};

  // Map an active-low g..a segment pattern to {hit, nibble}. A miss
  // returns hit = 0 and nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pat)
      7'b1000000: res = 5'b1_0000;
      7'b1111001: res = 5'b1_0001;
      7'b0100100: res = 5'b1_0010;
      7'b0110000: res = 5'b1_0011;
      7'b0011001: res = 5'b1_0100;
      7'b0010010: res = 5'b1_0101;
      7'b0000010: res = 5'b1_0110;
      7'b1111000: res = 5'b1_0111;
      7'b0000000: res = 5'b1_1000;
      7'b0010000: res = 5'b1_1001;
      7'b0001000: res = 5'b1_1010;
      7'b0000011: res = 5'b1_1011;
      7'b1000110: res = 5'b1_1100;
      7'b0100001: res = 5'b1_1101;
      7'b0000110: res = 5'b1_1110;
      7'b0001110: res = 5'b1_1111;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Two-flop synchroniser followed by the stability filter. The held
  // sample is reloaded whenever the synchronised lines differ from it,
  // which restarts the stability count and re-arms evaluation. Once the
  // count has reached its last value the held sample is evaluated exactly
  // once; "committed" blocks any repeat for the same stable episode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1     <= SAMPLE_IDLE;
      sync2     <= SAMPLE_IDLE;
      held      <= SAMPLE_IDLE;
      stab_cnt  <= 16'd0;
      committed <= 1'b0;
    end else begin
      sync1 <= sample_in;
      sync2 <= sync1;
      if (sync2 != held) begin
        held      <= sync2;
        stab_cnt  <= 16'd0;
        committed <= 1'b0;
      end else begin
        if (stab_cnt < STAB_LAST) begin
          stab_cnt <= stab_cnt + 16'd1;
        end
        if (eval_now) begin
          committed <= 1'b1;
        end
      end
    end
  end

  // Classify the held sample: which anode (if any) is driven, whether the
  // anode pattern is legal, and what glyph the segments form.
  always_comb begin
    held_an    = held[11:8];
    held_dp    = held[7];
    held_seg   = held[6:0];
    an_act     = ~held_an;
    an_blank   = (an_act == 4'b0000);
    an_multi   = ((an_act & (an_act - 4'd1)) != 4'b0000);
    dig_idx    = 2'd0;
    case (an_act)
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
    glyph      = decode_glyph(held_seg);
    glyph_hit  = glyph[4];
    glyph_code = glyph[3:0];
    eval_now   = (stab_cnt == STAB_LAST) && !committed;
    commit     = eval_now && !an_blank && !an_multi;
    seen_next  = seen | an_act;
  end

  // Output registers, frame tracking and the inactivity timeout. A digit
  // commit always wins over a timeout landing in the same cycle, so a
  // late-but-on-time digit never loses the valid state around it. After
  // firing, the timeout counter parks at its saturated value and stays
  // quiet until the next commit clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Digits   <= 16'h0000;
      DigValid <= 4'b0000;
      DpCapt   <= 4'b0000;
      FrameStb <= 1'b0;
      BadPat   <= 1'b0;
      BadAn    <= 1'b0;
      seen     <= 4'b0000;
      to_cnt   <= '0;
    end else begin
      FrameStb <= 1'b0;
      BadPat   <= 1'b0;
      BadAn    <= 1'b0;

      if (eval_now && an_multi) begin
        BadAn <= 1'b1;
      end

      if (commit) begin
        Digits[{dig_idx, 2'b00} +: 4] <= glyph_hit ? glyph_code : 4'h0;
        DigValid[dig_idx]             <= glyph_hit;
        DpCapt[dig_idx]               <= ~held_dp;
        if (!glyph_hit && (held_seg != 7'h7F)) begin
          BadPat <= 1'b1;
        end
        if (seen_next == 4'b1111) begin
          FrameStb <= 1'b1;
          seen     <= 4'b0000;
        end else begin
          seen <= seen_next;
        end
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt   <= TO_SAT;
        DigValid <= 4'b0000;
        seen     <= 4'b0000;
      end else if (to_cnt < TO_LAST) begin
        to_cnt <= to_cnt + TO_ONE;
      end
    end
  end

endmodule
